// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: owns the PC, keeps at most one imem request in
// flight and presents one instruction slot (INST_F/PC_F/PC4_F/VALID_F) to decode.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        STALL_F,
  input  logic        REDIRECT_F,
  input  logic [31:0] REDIRECT_PC,
  output logic        IMEM_REQ_VALID,
  input  logic        IMEM_REQ_READY,
  output logic [31:0] IMEM_ADDR,
  input  logic        IMEM_RSP_VALID,
  input  logic [31:0] IMEM_RSP_DATA,
  output logic [31:0] INST_F,
  output logic [31:0] PC_F,
  output logic [31:0] PC4_F,
  output logic        VALID_F
);

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] pc_f_q, pc_f_d;
  logic [31:0] pc4_f_q, pc4_f_d;
  logic        valid_q, valid_d;

  logic        slot_free;
  logic        req_valid;
  logic        req_fire;
  logic [31:0] redirect_pc_aligned;
  logic        redirect_pc_low_unused;

  assign redirect_pc_aligned    = {REDIRECT_PC[31:2], 2'b00};
  assign redirect_pc_low_unused = ^REDIRECT_PC[1:0];

  // Handshake: a request transfers on a cycle where IMEM_REQ_VALID and
  // IMEM_REQ_READY are both high; the address is held stable until then.
  // The response is a single-cycle IMEM_RSP_VALID pulse with no backpressure.
  always_comb begin
    slot_free = ~valid_q | ~STALL_F;
    req_valid = ~reset & (state_q == ST_REQ) & slot_free & ~REDIRECT_F;
    req_fire  = req_valid & IMEM_REQ_READY;
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    pc_f_d  = pc_f_q;
    pc4_f_d = pc4_f_q;
    valid_d = valid_q;

    // Decode takes the slot this cycle; leave a bubble unless refilled below.
    if (valid_q && !STALL_F) begin
      valid_d = 1'b0;
      inst_d  = NOP_INST;
    end

    if (REDIRECT_F) begin
      pc_d    = redirect_pc_aligned;
      valid_d = 1'b0;
      inst_d  = NOP_INST;
      unique case (state_q)
        ST_REQ:  state_d = ST_REQ;
        ST_WAIT: state_d = IMEM_RSP_VALID ? ST_REQ : ST_DROP;
        ST_DROP: state_d = IMEM_RSP_VALID ? ST_REQ : ST_DROP;
        default: state_d = ST_REQ;
      endcase
    end else begin
      unique case (state_q)
        ST_REQ: begin
          if (req_fire) state_d = ST_WAIT;
        end
        ST_WAIT: begin
          // The slot is empty here: requests only launch into a free slot.
          if (IMEM_RSP_VALID) begin
            inst_d  = IMEM_RSP_DATA;
            pc_f_d  = pc_q;
            pc4_f_d = pc_q + 32'd4;
            valid_d = 1'b1;
            pc_d    = pc_q + 32'd4;
            state_d = ST_REQ;
          end
        end
        ST_DROP: begin
          if (IMEM_RSP_VALID) state_d = ST_REQ;
        end
        default: state_d = ST_REQ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_REQ;
      pc_q    <= RESET_PC;
      inst_q  <= NOP_INST;
      pc_f_q  <= 32'h0000_0000;
      pc4_f_q <= 32'h0000_0000;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      pc_f_q  <= pc_f_d;
      pc4_f_q <= pc4_f_d;
      valid_q <= valid_d;
    end
  end

  assign IMEM_REQ_VALID = req_valid;
  assign IMEM_ADDR      = pc_q;
  assign INST_F         = inst_q;
  assign PC_F           = pc_f_q;
  assign PC4_F          = pc4_f_q;
  assign VALID_F        = valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus a randomized run checked
// against a program-order model of the fetched instruction stream.
module tb_fetch_stage;

  localparam logic [31:0] TB_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] TB_NOP      = 32'h0000_0013;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, stall_f, redirect_f;
  logic [31:0] redirect_pc;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic [31:0] inst_f, pc_f, pc4_f;
  logic        valid_f;

  logic        reset_2, rsp_valid_2, req_valid_2, valid_f_2;
  logic [31:0] rsp_data_2, addr_2, inst_f_2, pc_f_2, pc4_f_2;

  fetch_stage #(.RESET_PC(TB_RESET_PC), .NOP_INST(TB_NOP)) dut (
    .clk(clk), .reset(reset), .STALL_F(stall_f), .REDIRECT_F(redirect_f),
    .REDIRECT_PC(redirect_pc), .IMEM_REQ_VALID(imem_req_valid),
    .IMEM_REQ_READY(imem_req_ready), .IMEM_ADDR(imem_addr),
    .IMEM_RSP_VALID(imem_rsp_valid), .IMEM_RSP_DATA(imem_rsp_data),
    .INST_F(inst_f), .PC_F(pc_f), .PC4_F(pc4_f), .VALID_F(valid_f)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC), .NOP_INST(TB_NOP)) dut_wrap (
    .clk(clk), .reset(reset_2), .STALL_F(1'b0), .REDIRECT_F(1'b0),
    .REDIRECT_PC(32'h0), .IMEM_REQ_VALID(req_valid_2),
    .IMEM_REQ_READY(1'b1), .IMEM_ADDR(addr_2),
    .IMEM_RSP_VALID(rsp_valid_2), .IMEM_RSP_DATA(rsp_data_2),
    .INST_F(inst_f_2), .PC_F(pc_f_2), .PC4_F(pc4_f_2), .VALID_F(valid_f_2)
  );

  int vec_cnt = 0;
  int err_cnt = 0;

  // next-cycle stimulus, applied just after each rising edge
  logic        nx_reset = 1'b1, nx_stall = 1'b0, nx_redirect = 1'b0, nx_ready = 1'b1;
  logic [31:0] nx_rpc = 32'h0;
  logic        nx2_reset = 1'b1, nx2_rsp = 1'b0;
  logic [31:0] nx2_data = 32'h0;
  logic        rdy_rand = 1'b0;
  logic        mem_reset_clears = 1'b1;
  int          lat_lo = 1, lat_hi = 1;

  // memory model: one in-flight response with its word waiting in exp_q
  logic [31:0] exp_q[$];
  logic        pending = 1'b0;
  int          cnt = 0;
  logic        fired = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: mem_word = 32'h0010_0093;
      32'h0000_0004: mem_word = 32'h0020_0113;
      32'h0000_0008: mem_word = 32'h0050_0093;
      default:       mem_word = {a[15:0] ^ 16'h5A5A, a[31:16] ^ 16'h0F0F} ^ 32'h0000_0033;
    endcase
  endfunction

  initial begin
    reset = 1'b1; stall_f = 1'b0; redirect_f = 1'b0; redirect_pc = 32'h0;
    imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    reset_2 = 1'b1; rsp_valid_2 = 1'b0; rsp_data_2 = 32'h0;
  end

  // driver: one clock cycle; returns at the falling edge with outputs settled
  task automatic tick();
    @(posedge clk);
    #1;
    reset       = nx_reset;
    stall_f     = nx_stall;
    redirect_f  = nx_redirect;
    redirect_pc = nx_rpc;
    imem_req_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : nx_ready;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = $urandom;
    if (nx_reset && mem_reset_clears) begin
      pending = 1'b0;
      exp_q.delete();
    end
    if (pending) begin
      cnt = cnt - 1;
      if (cnt == 0) begin
        imem_rsp_valid = 1'b1;
        if (exp_q.size() > 0) imem_rsp_data = exp_q.pop_front();
        pending = 1'b0;
      end
    end
    reset_2     = nx2_reset;
    rsp_valid_2 = nx2_rsp;
    rsp_data_2  = nx2_data;
    @(negedge clk);
    fired = imem_req_valid & imem_req_ready;
    if (fired) begin
      pending = 1'b1;
      cnt = $urandom_range(lat_lo, lat_hi);
      exp_q.delete();
      exp_q.push_back(mem_word(imem_addr));
    end
  endtask

  task automatic test_reset();
    nx_reset = 1'b1;
    tick();
    vec_cnt++; if (imem_req_valid !== 1'b0) begin err_cnt++; $display("FAIL rst_req_valid got %b want 0", imem_req_valid); end
    tick();
    vec_cnt++; if (imem_req_valid !== 1'b0) begin err_cnt++; $display("FAIL rst_req_valid2 got %b want 0", imem_req_valid); end
    vec_cnt++; if (valid_f !== 1'b0) begin err_cnt++; $display("FAIL rst_valid got %b want 0", valid_f); end
    vec_cnt++; if (inst_f !== TB_NOP) begin err_cnt++; $display("FAIL rst_inst got %h want %h", inst_f, TB_NOP); end
    vec_cnt++; if (pc_f !== 32'h0 || pc4_f !== 32'h0) begin err_cnt++; $display("FAIL rst_pc got %h/%h want 0/0", pc_f, pc4_f); end
    vec_cnt++; if (imem_addr !== TB_RESET_PC) begin err_cnt++; $display("FAIL rst_addr got %h want %h", imem_addr, TB_RESET_PC); end
    nx_reset = 1'b0;
  endtask

  task automatic test_fetch();
    for (int i = 0; i < 3; i++) begin
      tick();
      vec_cnt++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'(4 * i)) begin
        err_cnt++; $display("FAIL fetch_req%0d got v=%b a=%h want v=1 a=%h", i, imem_req_valid, imem_addr, 32'(4 * i)); end
      if (i > 0) begin
        vec_cnt++; if (valid_f !== 1'b1 || pc_f !== 32'(4 * (i - 1)) || pc4_f !== 32'(4 * i) || inst_f !== mem_word(32'(4 * (i - 1)))) begin
          err_cnt++; $display("FAIL fetch_out%0d got v=%b pc=%h pc4=%h inst=%h", i, valid_f, pc_f, pc4_f, inst_f); end
      end
      tick();
      vec_cnt++; if (imem_req_valid !== 1'b0 || valid_f !== 1'b0) begin
        err_cnt++; $display("FAIL fetch_gap%0d got req=%b valid=%b want 0/0", i, imem_req_valid, valid_f); end
    end
  endtask

  task automatic test_stall();
    nx_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      vec_cnt++; if (valid_f !== 1'b1 || inst_f !== 32'h0050_0093 || pc_f !== 32'h8 || pc4_f !== 32'hC) begin
        err_cnt++; $display("FAIL stall_hold%0d got v=%b inst=%h pc=%h pc4=%h", i, valid_f, inst_f, pc_f, pc4_f); end
      vec_cnt++; if (imem_req_valid !== 1'b0) begin err_cnt++; $display("FAIL stall_noreq%0d got %b want 0", i, imem_req_valid); end
    end
    nx_stall = 1'b0;
    tick();
    vec_cnt++; if (valid_f !== 1'b1 || pc_f !== 32'h8 || imem_req_valid !== 1'b1 || imem_addr !== 32'hC) begin
      err_cnt++; $display("FAIL stall_release got v=%b pc=%h req=%b addr=%h want 1/8/1/c", valid_f, pc_f, imem_req_valid, imem_addr); end
  endtask

  task automatic test_redirect_wait();
    cnt = 3;
    if (exp_q.size() > 0) exp_q[0] = 32'hDEAD_BEEF;
    nx_redirect = 1'b1; nx_rpc = 32'h0000_0103;
    tick();
    vec_cnt++; if (imem_req_valid !== 1'b0 || valid_f !== 1'b0) begin
      err_cnt++; $display("FAIL rdw_cycle got req=%b valid=%b want 0/0", imem_req_valid, valid_f); end
    nx_redirect = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      vec_cnt++; if (imem_req_valid !== 1'b0 || valid_f !== 1'b0) begin
        err_cnt++; $display("FAIL rdw_drop%0d got req=%b valid=%b want 0/0", i, imem_req_valid, valid_f); end
    end
    tick();
    vec_cnt++; if (valid_f !== 1'b0 || imem_req_valid !== 1'b1 || imem_addr !== 32'h100) begin
      err_cnt++; $display("FAIL rdw_next got v=%b req=%b addr=%h want 0/1/100", valid_f, imem_req_valid, imem_addr); end
  endtask

  task automatic test_redirect_rsp();
    nx_redirect = 1'b1; nx_rpc = 32'h0000_0208;
    tick();
    vec_cnt++; if (imem_req_valid !== 1'b0) begin err_cnt++; $display("FAIL rdr_req got %b want 0", imem_req_valid); end
    nx_redirect = 1'b0;
    tick();
    vec_cnt++; if (valid_f !== 1'b0 || imem_req_valid !== 1'b1 || imem_addr !== 32'h208) begin
      err_cnt++; $display("FAIL rdr_next got v=%b req=%b addr=%h want 0/1/208", valid_f, imem_req_valid, imem_addr); end
    tick();
    tick();
    vec_cnt++; if (valid_f !== 1'b1 || pc_f !== 32'h208 || pc4_f !== 32'h20C || inst_f !== mem_word(32'h208)) begin
      err_cnt++; $display("FAIL rdr_out got v=%b pc=%h pc4=%h inst=%h", valid_f, pc_f, pc4_f, inst_f); end
  endtask

  task automatic test_ready_low();
    int n;
    nx_ready = 1'b0;
    n = 0;
    do begin tick(); n++; end while (imem_req_valid !== 1'b1 && n < 10);
    vec_cnt++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h210) begin
      err_cnt++; $display("FAIL rdy_first got req=%b addr=%h want 1/210", imem_req_valid, imem_addr); end
    for (int i = 0; i < 3; i++) begin
      tick();
      vec_cnt++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h210) begin
        err_cnt++; $display("FAIL rdy_hold%0d got req=%b addr=%h want 1/210", i, imem_req_valid, imem_addr); end
    end
    nx_ready = 1'b1;
    tick();
    vec_cnt++; if (!fired || imem_addr !== 32'h210) begin
      err_cnt++; $display("FAIL rdy_accept got fire=%b addr=%h want 1/210", fired, imem_addr); end
  endtask

  task automatic test_reset_wait();
    int n;
    lat_lo = 3; lat_hi = 3; mem_reset_clears = 1'b0;
    n = 0;
    do begin tick(); n++; end while (!fired && n < 10);
    vec_cnt++; if (!fired) begin err_cnt++; $display("FAIL rw_fire got 0 want 1"); end
    nx_reset = 1'b1;
    tick();
    vec_cnt++; if (imem_req_valid !== 1'b0) begin err_cnt++; $display("FAIL rw_req_in_reset got %b want 0", imem_req_valid); end
    nx_reset = 1'b0; nx_ready = 1'b0; lat_lo = 1; lat_hi = 1;
    tick();
    vec_cnt++; if (valid_f !== 1'b0 || inst_f !== TB_NOP || pc_f !== 32'h0 || pc4_f !== 32'h0 || imem_addr !== TB_RESET_PC) begin
      err_cnt++; $display("FAIL rw_outs got v=%b inst=%h pc=%h pc4=%h addr=%h", valid_f, inst_f, pc_f, pc4_f, imem_addr); end
    tick();
    nx_ready = 1'b1;
    tick();
    vec_cnt++; if (valid_f !== 1'b0 || imem_req_valid !== 1'b1 || imem_addr !== TB_RESET_PC) begin
      err_cnt++; $display("FAIL rw_late_rsp got v=%b req=%b addr=%h", valid_f, imem_req_valid, imem_addr); end
    tick();
    tick();
    vec_cnt++; if (valid_f !== 1'b1 || pc_f !== TB_RESET_PC || inst_f !== mem_word(TB_RESET_PC)) begin
      err_cnt++; $display("FAIL rw_refetch got v=%b pc=%h inst=%h", valid_f, pc_f, inst_f); end
    mem_reset_clears = 1'b1;
  endtask

  task automatic test_wrap();
    nx2_reset = 1'b0;
    tick();
    vec_cnt++; if (req_valid_2 !== 1'b1 || addr_2 !== 32'hFFFF_FFFC) begin
      err_cnt++; $display("FAIL wrap_req0 got v=%b a=%h want 1/fffffffc", req_valid_2, addr_2); end
    nx2_rsp = 1'b1; nx2_data = 32'h0070_0193;
    tick();
    nx2_rsp = 1'b0;
    tick();
    vec_cnt++; if (valid_f_2 !== 1'b1 || pc_f_2 !== 32'hFFFF_FFFC || pc4_f_2 !== 32'h0 || inst_f_2 !== 32'h0070_0193) begin
      err_cnt++; $display("FAIL wrap_out got v=%b pc=%h pc4=%h inst=%h", valid_f_2, pc_f_2, pc4_f_2, inst_f_2); end
    vec_cnt++; if (req_valid_2 !== 1'b1 || addr_2 !== 32'h0) begin
      err_cnt++; $display("FAIL wrap_req1 got v=%b a=%h want 1/0", req_valid_2, addr_2); end
  endtask

  task automatic test_random();
    logic [31:0] exp_pc, prev_inst, prev_pc, prev_pc4;
    logic        hold_prev;
    int          cons_cnt;
    rdy_rand = 1'b1; lat_lo = 1; lat_hi = 3; mem_reset_clears = 1'b1;
    nx_stall = 1'b0; nx_redirect = 1'b0;
    nx_reset = 1'b1;
    tick();
    exp_pc = TB_RESET_PC; hold_prev = 1'b0; cons_cnt = 0;
    prev_inst = '0; prev_pc = '0; prev_pc4 = '0;
    for (int i = 0; i < 3000; i++) begin
      nx_reset    = ($urandom_range(0, 99) == 0);
      nx_stall    = ($urandom_range(0, 9) < 3);
      nx_redirect = ($urandom_range(0, 19) == 0);
      nx_rpc      = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : ($urandom & 32'h0000_0FFF);
      tick();
      if (reset || redirect_f || (valid_f && stall_f)) begin
        vec_cnt++; if (imem_req_valid !== 1'b0) begin
          err_cnt++; $display("FAIL rnd_req_blocked cyc %0d got %b want 0", i, imem_req_valid); end
      end
      if (imem_req_valid) begin
        vec_cnt++; if (imem_addr[1:0] !== 2'b00) begin
          err_cnt++; $display("FAIL rnd_align cyc %0d addr %h", i, imem_addr); end
      end
      if (hold_prev) begin
        vec_cnt++; if (valid_f !== 1'b1 || inst_f !== prev_inst || pc_f !== prev_pc || pc4_f !== prev_pc4) begin
          err_cnt++; $display("FAIL rnd_hold cyc %0d got v=%b pc=%h inst=%h want 1/%h/%h", i, valid_f, pc_f, inst_f, prev_pc, prev_inst); end
      end
      if (imem_rsp_valid && valid_f && stall_f) begin
        vec_cnt++; err_cnt++; $display("FAIL rnd_rsp_to_full_slot cyc %0d", i);
      end
      if (!reset && !redirect_f && valid_f && !stall_f) begin
        vec_cnt++; if (pc_f !== exp_pc || inst_f !== mem_word(pc_f) || pc4_f !== pc_f + 32'd4) begin
          err_cnt++; $display("FAIL rnd_stream cyc %0d got pc=%h inst=%h pc4=%h want pc=%h inst=%h", i, pc_f, inst_f, pc4_f, exp_pc, mem_word(exp_pc)); end
        exp_pc = exp_pc + 32'd4;
        cons_cnt++;
      end
      hold_prev = !reset && !redirect_f && valid_f && stall_f;
      prev_inst = inst_f; prev_pc = pc_f; prev_pc4 = pc4_f;
      if (reset) exp_pc = TB_RESET_PC;
      else if (redirect_f) exp_pc = {redirect_pc[31:2], 2'b00};
    end
    vec_cnt++; if (cons_cnt < 100) begin
      err_cnt++; $display("FAIL rnd_progress got %0d instructions want >= 100", cons_cnt); end
    rdy_rand = 1'b0; nx_reset = 1'b0; nx_stall = 1'b0; nx_redirect = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_stall();
    test_redirect_wait();
    test_redirect_rsp();
    test_ready_low();
    test_reset_wait();
    test_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #1_000_000;
    err_cnt++;
    $display("FAIL watchdog time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage RV32I pipeline.
- Owns the PC register and issues one request at a time to instruction memory over a valid/ready request channel with an unbackpressured response.
- Presents INST_F / PC_F / PC4_F / VALID_F to the fetch→decode pipeline register.
- Honours hazard-unit stall and branch/jump redirect (flush).

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
NOP_INST, 32'h0000_0013, instruction driven on INST_F when VALID_F=0 (addi x0,x0,0).

Ports:
clk  input  1  clock; all state updates on rising edge.
reset  input  1  synchronous, active-high reset.
STALL_F  input  1  hazard unit: hold the current fetch output.
REDIRECT_F  input  1  taken branch/jump from execute; flush and restart fetch.
REDIRECT_PC  input  32  target PC for redirect.
IMEM_REQ_VALID  output  1  fetch request valid.
IMEM_REQ_READY  input  1  imem accepts the request.
IMEM_ADDR  output  32  request address; word-aligned.
IMEM_RSP_VALID  input  1  response valid; one cycle pulse, cannot be stalled.
IMEM_RSP_DATA  input  32  fetched instruction.
INST_F  output  32  instruction to the decode pipeline register.
PC_F  output  32  PC of INST_F.
PC4_F  output  32  PC_F + 4.
VALID_F  output  1  INST_F holds a real instruction; 0 means bubble.

Behaviour:
- Reset values, applied on the edge where reset=1:
  - pc = RESET_PC; state = REQ.
  - VALID_F = 0; INST_F = NOP_INST; PC_F = 0; PC4_F = 0.
- IMEM_REQ_VALID is 0 whenever reset=1.
- Output slot:
  - Slot is consumed in a cycle with VALID_F=1 and STALL_F=0.
  - Slot is free when VALID_F=0 or it is being consumed this cycle.
  - On consumption with no new capture: VALID_F←0 and INST_F←NOP_INST. PC_F/PC4_F hold.
- States: REQ, WAIT, DROP (one outstanding request maximum).
- REQ:
  - IMEM_REQ_VALID = slot_free & ~REDIRECT_F; IMEM_ADDR = pc.
  - On IMEM_REQ_VALID & IMEM_REQ_READY: go to WAIT.
- WAIT:
  - IMEM_REQ_VALID = 0.
  - On IMEM_RSP_VALID: INST_F←IMEM_RSP_DATA, PC_F←pc, PC4_F←pc+4, VALID_F←1, pc←pc+4, go to REQ.
  - The slot is always free at capture, because requests are issued only when the slot is free.
- DROP:
  - IMEM_REQ_VALID = 0.
  - On IMEM_RSP_VALID: discard the data, go to REQ.
- Redirect (REDIRECT_F=1) has priority over all of the above except reset:
  - pc ← {REDIRECT_PC[31:2], 2'b00}.
  - VALID_F←0, INST_F←NOP_INST, regardless of STALL_F.
  - REQ: no request is issued this cycle; stay in REQ.
  - WAIT without IMEM_RSP_VALID: go to DROP.
  - WAIT with IMEM_RSP_VALID: discard the response, go to REQ.
  - DROP without IMEM_RSP_VALID: stay in DROP, new pc taken.
  - DROP with IMEM_RSP_VALID: go to REQ.
- STALL_F=1 with VALID_F=1: INST_F / PC_F / PC4_F / VALID_F hold. No new request is issued; an outstanding response still completes and is captured only if the slot is free.
  - Invariant: a response never arrives to a full slot. The bench asserts this.
- Arithmetic: PC+4 is modulo 2^32 (0xFFFF_FFFC → 0x0000_0000).
- Latency: request accepted at edge t; response at edge ≥ t+1; VALID_F=1 at the edge after the response. With zero-wait memory, peak throughput is 1 instruction per 2 cycles.
- Reset mid-operation: an in-flight response after reset is ignored (state REQ ignores IMEM_RSP_VALID).

Test Plan:
- Reset then free-running fetch, IMEM_REQ_READY=1, 1-cycle response, STALL_F=0 → IMEM_ADDR sequence 0x0, 0x4, 0x8; PC_F 0x0/0x4/0x8 with PC4_F = PC_F+4; VALID_F pulses with correct INST_F.
- STALL_F held 3 cycles while VALID_F=1 (INST_F=0x00500093, PC_F=0x8) → outputs frozen, IMEM_REQ_VALID=0; after release the next request is 0xC.
- REDIRECT_F with REDIRECT_PC=0x103 while in WAIT, response arrives 2 cycles later with 0xDEADBEEF → response dropped, VALID_F stays 0, next IMEM_ADDR = 0x100.
- REDIRECT_F in the same cycle as IMEM_RSP_VALID → data discarded, VALID_F=0, next request at the redirect target.
- RESET_PC=0xFFFF_FFFC → first PC4_F = 0x0000_0000 and second IMEM_ADDR = 0x0.
- IMEM_REQ_READY low for 4 cycles → IMEM_REQ_VALID and IMEM_ADDR stable until accepted. Synchronous reset asserted in WAIT → all outputs take reset values next edge; late response ignored; next IMEM_ADDR = RESET_PC.
